// File: rtl/mixer_pkg.sv
// Shared types and helpers for the mixer matrix: FSM state encoding and
// the accumulator sizing rule (product width plus growth for NI terms).
package mixer_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    EMIT    = 2'd2
  } mix_state_e;

  function automatic int acc_width(input int dw, input int cw, input int ni);
    return dw + cw + $clog2(ni);
  endfunction

endpackage

// File: rtl/mixer_matrix_if.sv
// Input and output sample streams of the mixer. "master" is the
// upstream/downstream side, "slave" is the mixer block itself.
interface mixer_matrix_if #(
  parameter int DW   = 24,
  parameter int TIDW = 8
);
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [TIDW-1:0] s_axis_tid;

  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [TIDW-1:0] m_axis_tid;
  logic            m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast
  );
endinterface

// File: rtl/mixer_sat.sv
// Converts a Q(CQ) accumulator to a DW-bit sample: floor shift by CQ,
// then clamp to the signed DW-bit range.
module mixer_sat #(
  parameter int ACCW = 44,
  parameter int DW   = 24,
  parameter int CQ   = 16
) (
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [DW-1:0]   sat_o
);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACCW-1:0] shifted;

  // Arithmetic shift rounds toward minus infinity.
  assign shifted = acc_i >>> CQ;

  // Clamp the shifted value into the output sample range.
  always_comb begin
    sat_o = shifted[DW-1:0];
    if (shifted > MAXV) begin
      sat_o = MAXV[DW-1:0];
    end else if (shifted < MINV) begin
      sat_o = MINV[DW-1:0];
    end
  end
endmodule

// File: rtl/mixer_matrix.sv
// NI-in / NO-out gain matrix. Collects one sample per input channel,
// snapshots the coefficients, then computes each output with one
// multiply-accumulate per cycle and emits it on the output stream.
module mixer_matrix
  import mixer_pkg::*;
#(
  parameter int DW    = 24,
  parameter int COEFW = 18,
  parameter int CQ    = 16,
  parameter int NI    = 4,
  parameter int NO    = 2,
  parameter int TIDW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mixer_matrix_if.slave           bus,
  input  logic signed [COEFW-1:0] coefs [NO][NI]
);
  localparam int ACCW = acc_width(DW, COEFW, NI);
  localparam int PW   = DW + COEFW;
  localparam int SW   = (NI > 1) ? $clog2(NI) : 1;
  localparam int IW   = $clog2(NI + 1);
  localparam int OW   = (NO > 1) ? $clog2(NO) : 1;

  localparam logic [IW-1:0]   I_DONE   = IW'(NI);
  localparam logic [OW-1:0]   O_LAST   = OW'(NO - 1);
  localparam logic [TIDW-1:0] TID_LAST = TIDW'(NI - 1);

  mix_state_e state_q, state_d;
  logic [OW-1:0]            o_q, o_d;
  logic [IW-1:0]            i_q, i_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]     slot_q [NI];
  logic signed [DW-1:0]     slot_d [NI];
  logic signed [COEFW-1:0]  coef_q [NO][NI];
  logic signed [COEFW-1:0]  coef_d [NO][NI];
  logic [DW-1:0]            tdata_q, tdata_d;
  logic [TIDW-1:0]          tid_q, tid_d;
  logic                     tlast_q, tlast_d;

  logic                     s_ready, m_valid, s_fire, m_fire;
  logic [SW-1:0]            i_idx;
  logic signed [PW-1:0]     prod;
  logic signed [DW-1:0]     sat_val;

  // Handshakes are held off while reset is asserted.
  assign s_ready = (state_q == COLLECT) && !rst;
  assign m_valid = (state_q == EMIT) && !rst;
  assign s_fire  = bus.s_axis_tvalid && s_ready;
  assign m_fire  = m_valid && bus.m_axis_tready;

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tlast  = tlast_q;

  // The counter reaches NI on the output cycle; keep the index in range then.
  assign i_idx = (i_q < I_DONE) ? i_q[SW-1:0] : '0;
  assign prod  = slot_q[i_idx] * coef_q[o_q][i_idx];

  mixer_sat #(.ACCW(ACCW), .DW(DW), .CQ(CQ)) u_sat (
    .acc_i (acc_q),
    .sat_o (sat_val)
  );

  // Next-state logic: slot capture, coefficient snapshot, MAC sequencing, output.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    acc_d   = acc_q;
    slot_d  = slot_q;
    coef_d  = coef_q;
    tdata_d = tdata_q;
    tid_d   = tid_q;
    tlast_d = tlast_q;
    case (state_q)
      COLLECT: begin
        if (s_fire && (bus.s_axis_tid <= TID_LAST)) begin
          for (int k = 0; k < NI; k++) begin
            if (bus.s_axis_tid == TIDW'(k)) slot_d[k] = bus.s_axis_tdata;
          end
          if (bus.s_axis_tid == TID_LAST) begin
            coef_d  = coefs;
            state_d = MAC;
            o_d     = '0;
            i_d     = '0;
            acc_d   = '0;
          end
        end
      end
      MAC: begin
        if (i_q == I_DONE) begin
          tdata_d = sat_val;
          tid_d   = TIDW'(o_q);
          tlast_d = (o_q == O_LAST);
          state_d = EMIT;
        end else begin
          acc_d = acc_q + ACCW'(prod);
          i_d   = i_q + IW'(1);
        end
      end
      EMIT: begin
        if (m_fire) begin
          if (o_q == O_LAST) begin
            state_d = COLLECT;
          end else begin
            o_d     = o_q + OW'(1);
            i_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      o_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      tdata_q <= '0;
      tid_q   <= '0;
      tlast_q <= 1'b0;
      for (int k = 0; k < NI; k++) slot_q[k] <= '0;
      for (int o = 0; o < NO; o++) begin
        for (int k = 0; k < NI; k++) coef_q[o][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      tdata_q <= tdata_d;
      tid_q   <= tid_d;
      tlast_q <= tlast_d;
      slot_q  <= slot_d;
      coef_q  <= coef_d;
    end
  end
endmodule

// File: tb/tb_mixer_matrix.sv
// Scoreboard bench for mixer_matrix: a reference model pushes expected
// output beats when a frame completes; the monitor pops and compares.
module tb_mixer_matrix;
  localparam int DW = 24, COEFW = 18, CQ = 16, NI = 4, NO = 2, TIDW = 8;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  typedef struct {
    longint data;
    longint tid;
    longint last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [COEFW-1:0] coefs [NO][NI];

  always #5 clk = ~clk;

  mixer_matrix_if #(.DW(DW), .TIDW(TIDW)) bus ();

  mixer_matrix #(
    .DW(DW), .COEFW(COEFW), .CQ(CQ), .NI(NI), .NO(NO), .TIDW(TIDW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .coefs (coefs)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     accept_cyc = 0;
  int     xfer_cyc   = 0;
  int     beats      = 0;
  logic   prev_valid = 1'b0;
  logic   expect_ready = 1'b0;
  longint m_slot [NI];
  exp_t   sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint model_out(input int o);
    longint acc = 0;
    longint y;
    for (int i = 0; i < NI; i++) acc += m_slot[i] * longint'(coefs[o][i]);
    y = acc >>> CQ;
    if (y > MAXV) y = MAXV;
    if (y < MINV) y = MINV;
    return y;
  endfunction

  task automatic set_all(input int v);
    for (int o = 0; o < NO; o++)
      for (int i = 0; i < NI; i++) coefs[o][i] = COEFW'(v);
  endtask

  task automatic set_identity();
    set_all(0);
    for (int o = 0; o < NO; o++) coefs[o][o] = COEFW'(65536);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input int tid, input longint data);
    int n = 0;
    exp_t e;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tid    = TIDW'(tid);
    bus.s_axis_tdata  = data[DW-1:0];
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_axis_tready && n < 100);
    if (!bus.s_axis_tready) begin
      check_eq("s_ready_timeout", 0, 1);
      bus.s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    $display("[TB] in  tid=%0d data=%0d", tid, data);
    if (tid < NI) m_slot[tid] = data;
    if (tid == NI - 1) begin
      accept_cyc = cyc;
      for (int o = 0; o < NO; o++) begin
        e.data = model_out(o);
        e.tid  = o;
        e.last = (o == NO - 1) ? 1 : 0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input longint a, input longint b, input longint c, input longint d);
    send_beat(0, a);
    send_beat(1, b);
    send_beat(2, c);
    send_beat(3, d);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.m_axis_tvalid) && n < 300);
    check_eq("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency, ready-after-last, and scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid   = 1'b0;
      expect_ready = 1'b0;
    end else begin
      if (expect_ready) begin
        check_eq("ready_after_last", bus.s_axis_tready, 1);
        expect_ready = 1'b0;
      end
      if (bus.m_axis_tvalid && !prev_valid) begin
        if (bus.m_axis_tid == 0) check_eq("latency_first", cyc - accept_cyc, NI + 1);
        else                     check_eq("latency_next", cyc - xfer_cyc, NI + 1);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats++;
        xfer_cyc = cyc + 1;
        $display("[TB] out tid=%0d data=%0d last=%0d", bus.m_axis_tid,
                 longint'($signed(bus.m_axis_tdata)), bus.m_axis_tlast);
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("tdata", longint'($signed(bus.m_axis_tdata)), e.data);
          check_eq("tid", bus.m_axis_tid, e.tid);
          check_eq("tlast", bus.m_axis_tlast, e.last);
        end
        if (bus.m_axis_tlast) expect_ready = 1'b1;
      end
      prev_valid = bus.m_axis_tvalid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]   d0;
    logic [TIDW-1:0] t0;
    logic            l0;
    int n;
    int beats_before;

    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tid    = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    set_all(0);
    for (int i = 0; i < NI; i++) m_slot[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", bus.m_axis_tvalid, 0);
    check_eq("rst_sready", bus.s_axis_tready, 0);
    check_eq("rst_tdata", bus.m_axis_tdata, 0);
    check_eq("rst_tid", bus.m_axis_tid, 0);
    check_eq("rst_tlast", bus.m_axis_tlast, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("sready_after_rst", bus.s_axis_tready, 1);
    @(posedge clk);
    #1;

    // Identity routing
    set_identity();
    send_frame(100, -200, 300, 400);
    wait_drain();

    // Saturation both directions
    set_all(131071);
    send_frame(8388607, 8388607, 8388607, 8388607);
    wait_drain();
    send_frame(-8388608, -8388608, -8388608, -8388608);
    wait_drain();

    // Backpressure in EMIT
    set_identity();
    bus.m_axis_tready = 1'b0;
    send_frame(5, 6, 7, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axis_tvalid && n < 50);
    check_eq("bp_tvalid_seen", bus.m_axis_tvalid, 1);
    d0 = bus.m_axis_tdata;
    t0 = bus.m_axis_tid;
    l0 = bus.m_axis_tlast;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("bp_tvalid", bus.m_axis_tvalid, 1);
      check_eq("bp_tdata_stable", bus.m_axis_tdata, d0);
      check_eq("bp_tid_stable", bus.m_axis_tid, t0);
      check_eq("bp_tlast_stable", bus.m_axis_tlast, l0);
      check_eq("bp_sready_low", bus.s_axis_tready, 0);
    end
    @(posedge clk);
    #1;
    bus.m_axis_tready = 1'b1;
    wait_drain();

    // Discarded out-of-range tid, then coefficient change during MAC
    set_all(32768);
    send_beat(7, 999);
    send_frame(1, 1, 1, 1);
    set_all(65536);
    wait_drain();

    // Reset during MAC of output 0
    set_identity();
    send_frame(1, 2, 3, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < NI; i++) m_slot[i] = 0;
    beats_before = beats;
    repeat (20) @(posedge clk);
    #1;
    check_eq("rst_no_beat", beats, beats_before);
    send_frame(10, 20, 30, 40);
    wait_drain();

    // Floor rounding of a negative half-step
    set_all(0);
    for (int o = 0; o < NO; o++) coefs[o][0] = COEFW'(32768);
    send_beat(0, -3);
    send_beat(3, 40);
    wait_drain();

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mixer_matrix.md
MIXER_MATRIX -- requirements
Module: mixer_matrix

Interface
REQ-001 The block SHALL have parameter DW, default 24, meaning sample width (signed).
REQ-002 The block SHALL have parameter COEFW, default 18, meaning coefficient width (signed).
REQ-003 The block SHALL have parameter CQ, default 16, meaning coefficient fractional bits (unity = 2^CQ).
REQ-004 The block SHALL have parameter NI, default 4, meaning input channel count.
REQ-005 The block SHALL have parameter NO, default 2, meaning output channel count.
REQ-006 The block SHALL have parameter TIDW, default 8, meaning channel-id width.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning sole clock; all logic rising-edge.
REQ-008 The block SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-009 The block SHALL have the s_axis_tdata/tvalid/tready/tid ports, with widths DW/1/1/TIDW, meaning the input sample stream.
REQ-010 The block SHALL have the m_axis_tdata/tvalid/tready/tid/tlast ports, with widths DW/1/1/TIDW/1, meaning the output sample stream.
REQ-011 The block SHALL have port coefs[NO][NI], input, COEFW each, meaning gain from input i to output o.

Function
REQ-012 Input beat SHALL transfer when s_axis_tvalid && s_axis_tready; m_axis beat SHALL transfer when m_axis_tvalid && m_axis_tready.
REQ-013 States SHALL be COLLECT, MAC, EMIT; s_axis_tready = 1 only in COLLECT.
REQ-014 In COLLECT, accepted beat with tid < NI SHALL write tdata into sample slot[tid]; repeated tid overwrites.
REQ-015 Accepted beat with tid >= NI SHALL be consumed and discarded, no state change.
REQ-016 Accepting tid == NI-1 SHALL complete the frame: same edge snapshots all coefs and goes COLLECT->MAC with o=0; slots never written since reset read as 0, stale slots reused.
REQ-017 MAC SHALL perform one product slot[i]*coef[o][i] per cycle, i=0..NI-1, into accumulator of width DW+COEFW+clog2(NI), cleared at start of each output.
REQ-018 After NI MAC cycles, result SHALL be arithmetically right-shifted by CQ (floor), saturated to [-2^(DW-1), 2^(DW-1)-1], registered to m_axis_tdata, m_axis_tid=o, m_axis_tlast=(o==NO-1), state EMIT.
REQ-019 m_axis_tvalid SHALL first assert NI+1 cycles after the accepting edge of tid NI-1.
REQ-020 In EMIT, m_axis_tdata/tid/tlast SHALL hold stable while tvalid && !tready.
REQ-021 On EMIT transfer: o<NO-1 -> MAC with o+1 (next tvalid NI+1 cycles later); o==NO-1 -> COLLECT, tready high next cycle.
REQ-022 Coefficient changes after the snapshot SHALL NOT affect the frame in flight.
REQ-023 m_axis_tvalid SHALL be 0 outside EMIT.

Reset
REQ-024 rst SHALL, at any state including mid-MAC or mid-EMIT, force COLLECT, clear all slots, accumulator, o, and coef snapshot; in-flight frame discarded.
REQ-025 Output values during and after reset SHALL be: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tlast=0, s_axis_tready=0 while rst high, and s_axis_tready=1 the cycle after rst deasserts.

Structure
REQ-026 Package mixer_pkg SHALL hold state enum and accumulator-width function.
REQ-027 Shift-and-saturate SHALL be sub-module mixer_sat (combinational, parameters ACCW, DW, CQ).

Verification
REQ-028 The bench SHALL cover the identity case: NI=4, NO=2, coefs[0]=[65536,0,0,0], coefs[1]=[0,65536,0,0], inputs tid0..3 = 100,-200,300,400 -> out (tid0,100,tlast0),(tid1,-200,tlast1), first tvalid 5 cycles after tid3 accept.
REQ-029 The bench SHALL cover saturation: all coefs 131071, all inputs 8388607 -> both outputs 8388607; all inputs -8388608 -> -8388608.
REQ-030 The bench SHALL cover backpressure: m_axis_tready low 10 cycles in EMIT -> tdata/tid/tlast stable, s_axis_tready 0 throughout; no sample lost.
REQ-031 The bench SHALL cover a bad tid plus coef change: send tid 7 value 999, then frame 1,1,1,1 with coefs 32768 all; change coefs during MAC -> out 2 on both channels.
REQ-032 The bench SHALL cover reset mid-frame: rst one cycle during MAC of output 0 -> no m_axis beat, then new frame 10,20,30,40 identity -> 10,20.
REQ-033 The bench SHALL cover floor rounding: coef 32768, input -3 only on slot 0 -> out -2.
